// File: rtl/wb_pkg.sv
// wb_pkg: writeback select and load-size encodings plus the alignment check
package wb_pkg;
   localparam logic [1:0] WB_SEL_ALU  = 2'd0;
   localparam logic [1:0] WB_SEL_MEM  = 2'd1;
   localparam logic [1:0] WB_SEL_LINK = 2'd2;
   localparam logic [1:0] MEM_BYTE  = 2'd0;
   localparam logic [1:0] MEM_HALF  = 2'd1;
   localparam logic [1:0] MEM_WORD  = 2'd2;
   localparam logic [1:0] MEM_DWORD = 2'd3;
   // a dword on a 32-bit build is checked as a word
   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lo, input logic wide);
      return size == MEM_HALF ? lo[0] :
             (size == MEM_WORD || (size == MEM_DWORD && !wide)) ? |lo[1:0] :
             size == MEM_DWORD ? |lo : 1'b0;
   endfunction
endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed lanes of a memory word and sign/zero-extends them
module load_align
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BIG_ENDIAN = 1,
   parameter int ADDR_LO_W  = $clog2(DATA_WIDTH/8)
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [ADDR_LO_W-1:0]  addr_lo,
   input  logic [1:0]            size,
   input  logic                  sgn,
   output logic [DATA_WIDTH-1:0] result
);
   typedef logic [DATA_WIDTH-1:0] word_t;
   logic       dword;
   logic [7:0] nbytes;
   logic [7:0] sh;
   word_t      shifted;
   // big-endian: the unit's LSB sits at DW - 8*(offset + bytes)
   always_comb begin
      dword   = DATA_WIDTH == 64 && size == MEM_DWORD;
      nbytes  = size == MEM_BYTE ? 8'd1 : size == MEM_HALF ? 8'd2 : dword ? 8'd8 : 8'd4;
      sh      = BIG_ENDIAN != 0 ? 8'(DATA_WIDTH) - ((8'(addr_lo) + nbytes) << 3) : 8'(addr_lo) << 3;
      shifted = data >> sh;
      result  = size == MEM_BYTE ? (sgn ? word_t'($signed(shifted[7:0])) : word_t'(shifted[7:0])) :
                size == MEM_HALF ? (sgn ? word_t'($signed(shifted[15:0])) : word_t'(shifted[15:0])) :
                dword ? shifted :
                (sgn ? word_t'($signed(shifted[31:0])) : word_t'(shifted[31:0]));
   end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: registered MIPS writeback select driving the regfile write port
module writeback_stage
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_LO_W   = $clog2(DATA_WIDTH/8),
   parameter int REG_ADDR_W  = 5,
   parameter int LINK_OFFSET = 8,
   parameter int BIG_ENDIAN  = 1,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  valid_in,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [1:0]            wb_sel,
   input  logic [1:0]            mem_size,
   input  logic                  mem_signed,
   input  logic [ADDR_LO_W-1:0]  addr_lo,
   input  logic [DATA_WIDTH-1:0] data_in_mem,
   input  logic [DATA_WIDTH-1:0] data_in_alu,
   input  logic [DATA_WIDTH-1:0] pc_in,
   input  logic [REG_ADDR_W-1:0] rd_in,
   input  logic                  reg_write_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [REG_ADDR_W-1:0] rd_out,
   output logic                  reg_we,
   output logic                  valid_out,
   output logic                  misalign_err,
   output logic [CNT_WIDTH-1:0]  retire_count
);
   typedef logic [DATA_WIDTH-1:0] word_t;
   word_t aligned;
   word_t sel_data;
   logic  mis;
   load_align #(.DATA_WIDTH(DATA_WIDTH), .BIG_ENDIAN(BIG_ENDIAN), .ADDR_LO_W(ADDR_LO_W)) u_align (
      .data    (data_in_mem),
      .addr_lo (addr_lo),
      .size    (mem_size),
      .sgn     (mem_signed),
      .result  (aligned)
   );
   // a misaligned load still retires but writes nothing; raw data is exposed for debug
   always_comb begin
      mis      = valid_in && wb_sel == WB_SEL_MEM && misaligned(mem_size, 3'(addr_lo), DATA_WIDTH == 64);
      sel_data = wb_sel == WB_SEL_MEM ? (mis ? data_in_mem : aligned) :
                 wb_sel == WB_SEL_LINK ? pc_in + word_t'(LINK_OFFSET) : data_in_alu;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         data_out     <= '0;
         rd_out       <= '0;
         reg_we       <= 1'b0;
         valid_out    <= 1'b0;
         misalign_err <= 1'b0;
         retire_count <= '0;
      end else if (flush || stall) begin
         reg_we       <= 1'b0;
         valid_out    <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         data_out     <= sel_data;
         rd_out       <= rd_in;
         reg_we       <= valid_in && reg_write_in && rd_in != '0 && !mis;
         valid_out    <= valid_in;
         misalign_err <= mis;
         if (valid_in) retire_count <= retire_count + 1'b1;
      end
   end
endmodule
